// File: rtl/word_serialiser.sv
// word_serialiser: pops 32-bit words from a FIFO and feeds them byte by byte to a UART TX
module word_serialiser #(
    parameter int FIFO_RD_LATENCY = 1,
    parameter bit MSB_FIRST       = 1'b1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_fifo_data,
    input  logic        i_fifo_empty,
    output logic        o_fifo_rd_en,
    output logic [7:0]  o_tx_byte_data,
    output logic        o_tx_byte_send_sig,
    input  logic        i_tx_active,
    input  logic        i_tx_done_sig,
    output logic        o_word_sent_sig,
    output logic        o_busy
);
    typedef enum logic [2:0] {IDLE, FIFO_RD, LATCH, SEND, WAIT_DONE} state_t;
    localparam logic [1:0] LAT_LAST = 2'(FIFO_RD_LATENCY - 1);
    state_t      state, state_n;
    logic [31:0] shift, shift_n;
    logic [1:0]  byte_cnt, byte_cnt_n, lat_cnt, lat_cnt_n;
    logic        rd_en_n, send_n, sent_n;
    logic [7:0]  tx_byte_n, cur_byte;
    assign cur_byte = MSB_FIRST ? shift[31:24] : shift[7:0];
    always_comb begin
        state_n    = state;
        shift_n    = shift;
        byte_cnt_n = byte_cnt;
        lat_cnt_n  = lat_cnt;
        rd_en_n    = 1'b0;
        send_n     = 1'b0;
        sent_n     = 1'b0;
        tx_byte_n  = o_tx_byte_data;
        case (state)
            IDLE: if (!i_fifo_empty && !i_tx_active) begin
                rd_en_n = 1'b1;
                state_n = FIFO_RD;
            end
            FIFO_RD: begin
                lat_cnt_n = (lat_cnt == LAT_LAST) ? 2'd0 : lat_cnt + 2'd1;
                state_n   = (lat_cnt == LAT_LAST) ? LATCH : FIFO_RD;
            end
            LATCH: begin
                shift_n    = i_fifo_data;
                byte_cnt_n = 2'd3;
                state_n    = SEND;
            end
            SEND: if (!i_tx_active) begin
                send_n    = 1'b1;
                tx_byte_n = cur_byte;
                state_n   = WAIT_DONE;
            end
            WAIT_DONE: if (i_tx_done_sig) begin
                if (byte_cnt != 2'd0) begin
                    shift_n    = MSB_FIRST ? shift << 8 : shift >> 8;
                    byte_cnt_n = byte_cnt - 2'd1;
                    state_n    = SEND;
                end else begin
                    sent_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state              <= IDLE;
            shift              <= '0;
            byte_cnt           <= '0;
            lat_cnt            <= '0;
            o_fifo_rd_en       <= 1'b0;
            o_tx_byte_data     <= '0;
            o_tx_byte_send_sig <= 1'b0;
            o_word_sent_sig    <= 1'b0;
            o_busy             <= 1'b0;
        end else begin
            state              <= state_n;
            shift              <= shift_n;
            byte_cnt           <= byte_cnt_n;
            lat_cnt            <= lat_cnt_n;
            o_fifo_rd_en       <= rd_en_n;
            o_tx_byte_data     <= tx_byte_n;
            o_tx_byte_send_sig <= send_n;
            o_word_sent_sig    <= sent_n;
            o_busy             <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_word_serialiser.sv
// tb_word_serialiser: randomized scoreboard bench with FIFO and UART TX models
module tb_word_serialiser;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst = 1'b0;
    logic [31:0] fifo_data = '0;
    logic        fifo_empty, rd_en, send, tx_active, tx_done, sent, busy;
    logic [7:0]  tx_byte;
    logic [31:0] b_data = '0;
    logic        b_empty = 1'b1, b_active = 1'b0, b_done = 1'b0;
    logic        b_rd_en, b_send, b_sent, b_busy;
    logic [7:0]  b_byte;

    word_serialiser dut (
        .i_clock(clk), .i_reset(rst), .i_fifo_data(fifo_data), .i_fifo_empty(fifo_empty),
        .o_fifo_rd_en(rd_en), .o_tx_byte_data(tx_byte), .o_tx_byte_send_sig(send),
        .i_tx_active(tx_active), .i_tx_done_sig(tx_done), .o_word_sent_sig(sent), .o_busy(busy)
    );
    word_serialiser #(.FIFO_RD_LATENCY(3), .MSB_FIRST(1'b0)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_fifo_data(b_data), .i_fifo_empty(b_empty),
        .o_fifo_rd_en(b_rd_en), .o_tx_byte_data(b_byte), .o_tx_byte_send_sig(b_send),
        .i_tx_active(b_active), .i_tx_done_sig(b_done), .o_word_sent_sig(b_sent), .o_busy(b_busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // stimulus-owned state
    int          phase = 0, tx_lat = 10, n_push = 0, eb_wr = 0, ew_wr = 0, to_count = 0;
    bit          tx_force = 1'b0, spur_done = 1'b0, b_go = 1'b0;
    logic [31:0] fifo_mem [256];
    logic [7:0]  exp_b [2048];
    logic [31:0] exp_w [512];

    // model-owned state
    int n_pop = 0, pop_cyc = -10, tx_rem = 0, b_pop_cyc = -10, b_rem = 0;
    bit tx_busy = 1'b0, tx_done_m = 1'b0, b_popped = 1'b0;
    logic [31:0] b_word_v = 32'h11223344;

    assign fifo_empty = (n_push == n_pop);
    assign tx_active  = tx_busy || tx_force;
    assign tx_done    = tx_done_m || spur_done;

    // FIFO with one cycle of read latency; data is only valid in that one cycle
    always @(negedge clk) begin
        if (rd_en && n_pop != n_push) begin
            pop_cyc = cyc;
            n_pop   = n_pop + 1;
        end
        fifo_data = (n_pop > 0 && cyc == pop_cyc + 1) ? fifo_mem[n_pop-1] : $urandom();
    end

    always @(negedge clk) begin
        if (rst) begin
            tx_busy = 1'b0; tx_done_m = 1'b0; tx_rem = 0;
        end else begin
            tx_done_m = 1'b0;
            if (tx_busy) begin
                tx_rem = tx_rem - 1;
                if (tx_rem == 0) begin tx_busy = 1'b0; tx_done_m = 1'b1; end
            end else if (send) begin
                tx_busy = 1'b1; tx_rem = tx_lat;
            end
        end
    end

    // second instance: latency-3 FIFO holding a single word, fixed 3-cycle TX
    always @(negedge clk) begin
        b_empty = !b_go || b_popped;
        if (b_rd_en && !b_popped) begin b_popped = 1'b1; b_pop_cyc = cyc; b_empty = 1'b1; end
        b_data = (b_popped && cyc == b_pop_cyc + 3) ? b_word_v : $urandom();
        b_done = 1'b0;
        if (b_active) begin
            b_rem = b_rem - 1;
            if (b_rem == 0) begin b_active = 1'b0; b_done = 1'b1; end
        end else if (b_send) begin
            b_active = 1'b1; b_rem = 3;
        end
    end

    // monitor / scoreboard
    int          tests = 0, fails = 0, eb_rd = 0, ew_rd = 0, acc_n = 0, rd_cyc = 0, bp_st = 0, to_seen = 0;
    int          b_idx = 0, b_rd_c = 0;
    bit          inflight = 1'b0, lat_pend = 1'b0, b_fin = 1'b0;
    logic [31:0] acc = '0;
    logic [7:0]  bp_byte = '0, b_exp;
    logic        empty_q = 1'b1, act_q = 1'b0, last_act = 1'b0;
    always @(posedge clk) begin
        empty_q <= fifo_empty;
        act_q   <= tx_active;
    end
    always @(negedge clk) begin
        if (to_count != to_seen) begin
            tests++; fails++;
            $display("FAIL wait_bound: %0d expired, required 0", to_count - to_seen);
            to_seen = to_count;
        end
        if (rst) begin
            tests++;
            if ({rd_en, send, sent, busy, tx_byte, b_rd_en, b_send, b_sent, b_busy, b_byte} != '0) begin
                fails++;
                $display("FAIL reset_outputs: got rd=%b send=%b sent=%b busy=%b byte=%h b_byte=%h, required all 0",
                         rd_en, send, sent, busy, tx_byte, b_byte);
            end
            eb_rd = eb_wr; ew_rd = ew_wr; acc_n = 0; inflight = 1'b0; lat_pend = 1'b0;
        end else begin
            if (rd_en) begin
                tests++;
                if (inflight || empty_q) begin
                    fails++;
                    $display("FAIL rd_en_legal: inflight=%b empty=%b, required 0 0", inflight, empty_q);
                end
                inflight = 1'b1; lat_pend = 1'b1; rd_cyc = cyc; acc_n = 0;
            end
            if (send) begin
                tests += 2;
                if (eb_rd == eb_wr) begin
                    fails++;
                    $display("FAIL byte: got unexpected %h, required none", tx_byte);
                end else begin
                    if (tx_byte != exp_b[eb_rd]) begin
                        fails++;
                        $display("FAIL byte: got %h, required %h", tx_byte, exp_b[eb_rd]);
                    end
                    eb_rd++;
                end
                if (act_q) begin
                    fails++;
                    $display("FAIL send_while_active: tx_active=%b, required 0", act_q);
                end
                acc = {acc[23:0], tx_byte};
                acc_n++;
                if (lat_pend) begin
                    lat_pend = 1'b0;
                    if (phase != 2) begin
                        tests++;
                        if (cyc - rd_cyc != 3) begin
                            fails++;
                            $display("FAIL first_byte_latency: got %0d, required 3", cyc - rd_cyc);
                        end
                    end
                end
            end
            if (sent) begin
                tests++;
                if (ew_rd == ew_wr) begin
                    fails++;
                    $display("FAIL word: got unexpected word_sent, required none");
                end else begin
                    if (acc != exp_w[ew_rd] || acc_n != 4) begin
                        fails++;
                        $display("FAIL word: got %h after %0d bytes, required %h after 4", acc, acc_n, exp_w[ew_rd]);
                    end
                    ew_rd++;
                end
                inflight = 1'b0;
            end
            if (phase == 1) begin
                tests++;
                if (rd_en || send || busy) begin
                    fails++;
                    $display("FAIL empty_idle: got rd=%b send=%b busy=%b, required 0 0 0", rd_en, send, busy);
                end
            end
            if (phase == 2 && bp_st < 2) begin
                tests++;
                if (bp_st == 0) begin bp_byte = tx_byte; bp_st = 1; end
                if (!act_q && last_act) begin
                    bp_st = 2;
                    if (!send) begin
                        fails++;
                        $display("FAIL bp_release: send=%b, required 1", send);
                    end
                end else if (send || tx_byte != bp_byte) begin
                    fails++;
                    $display("FAIL bp_hold: send=%b byte=%h, required 0 %h", send, tx_byte, bp_byte);
                end
            end
            if (phase != 2) bp_st = 0;
            if (b_rd_en) begin b_rd_c = cyc; b_idx = 0; end
            if (b_send) begin
                tests++;
                b_exp = 8'(b_word_v >> (8 * (b_idx & 3)));
                if (b_idx > 3 || b_byte != b_exp) begin
                    fails++;
                    $display("FAIL b_byte%0d: got %h, required %h", b_idx, b_byte, b_exp);
                end
                if (b_idx == 0) begin
                    tests++;
                    if (cyc - b_rd_c != 5) begin
                        fails++;
                        $display("FAIL b_latency: got %0d, required 5", cyc - b_rd_c);
                    end
                end
                b_idx++;
            end
            if (b_sent) begin
                tests++;
                if (b_idx != 4) begin
                    fails++;
                    $display("FAIL b_word_sent: got after %0d bytes, required 4", b_idx);
                end
                b_fin = 1'b1;
            end
        end
        last_act = act_q;
    end

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            exp_b[eb_wr] = 8'(w >> (8 * (3 - i)));
            eb_wr++;
        end
        exp_w[ew_wr] = w;
        ew_wr++;
        fifo_mem[n_push] = w;
        n_push++;
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        bit done = 1'b0;
        while (!done && k < limit) begin
            @(negedge clk);
            k++;
            done = (n_pop == n_push) && (eb_rd == eb_wr) && (ew_rd == ew_wr) && !busy && !tx_active;
        end
        if (!done) to_count++;
        @(negedge clk);
    endtask

    task automatic wait_rd(input int limit);
        int k = 0;
        while (!rd_en && k < limit) begin @(negedge clk); k++; end
        if (!rd_en) to_count++;
    endtask

    initial begin
        int k, n;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        b_go = 1'b1;
        k = 0;
        while (!b_fin && k < 200) begin @(negedge clk); k++; end
        if (!b_fin) to_count++;
        tx_lat = 10;
        push_word(32'hDEADBEEF);
        wait_idle(300);
        push_word(32'h01234567);
        push_word(32'h89ABCDEF);
        wait_idle(600);
        phase = 1;
        repeat (100) @(negedge clk);
        phase = 0;
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        push_word(32'hA5C30F96);
        wait_rd(50);
        tx_force = 1'b1;
        phase = 2;
        repeat (20) @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (29) @(negedge clk);
        tx_force = 1'b0;
        wait_idle(400);
        phase = 0;
        tx_lat = 6;
        push_word(32'hCAFEF00D);
        n = 0; k = 0;
        while (n < 2 && k < 200) begin @(negedge clk); k++; if (send) n++; end
        if (n < 2) to_count++;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tx_lat = 4;
        push_word(32'h1234ABCD);
        wait_idle(300);
        repeat (25) begin
            tx_lat = $urandom_range(1, 12);
            push_word($urandom());
            if ($urandom_range(0, 3) == 0) wait_idle(500);
            else repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        wait_idle(5000);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/word_serialiser.md
Name: word_serialiser

Overview:
- Transmit-direction counterpart of the UART-to-FIFO byte deserialiser.
- Pops 32-bit words from the outbound FIFO and splits each into 4 bytes. Bytes go to the UART transmitter one at a time, each paced by the transmitter's done handshake.
- Byte order is MSB first: byte [31:24] is sent first. A word round-tripped through the deserialiser is therefore reassembled unchanged.
- Sits between the outbound 32-bit FIFO read port and the PC-link UART TX.

Parameters:
- FIFO_RD_LATENCY, default 1: clock cycles from the o_fifo_rd_en pulse to valid i_fifo_data. Legal range 1..3.
- MSB_FIRST, default 1: 1 sends [31:24] first; 0 sends [7:0] first.

Ports:
- i_clock  input  1  system clock; all logic on the rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_fifo_data  input  32  FIFO read data; valid FIFO_RD_LATENCY cycles after the rd_en pulse.
- i_fifo_empty  input  1  FIFO empty flag.
- o_fifo_rd_en  output  1  one-cycle FIFO pop strobe.
- o_tx_byte_data  output  8  byte presented to the UART TX.
- o_tx_byte_send_sig  output  1  one-cycle strobe: UART TX loads o_tx_byte_data.
- i_tx_active  input  1  UART TX is currently shifting a byte.
- i_tx_done_sig  input  1  one-cycle strobe from UART TX: byte finished.
- o_word_sent_sig  output  1  one-cycle strobe: all 4 bytes of the current word done.
- o_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; shift register=0; byte counter=0; latency counter=0; all outputs 0.
- All outputs are registered. Strobes are exactly one cycle wide.
- States: IDLE, FIFO_RD, LATCH, SEND, WAIT_DONE.
- IDLE:
  - If i_fifo_empty=0 and i_tx_active=0: assert o_fifo_rd_en for one cycle and go to FIFO_RD.
  - Otherwise stay in IDLE; o_fifo_rd_en=0.
- FIFO_RD:
  - Count FIFO_RD_LATENCY cycles from the rd_en pulse, then go to LATCH.
  - i_fifo_empty is ignored in this state.
- LATCH:
  - Capture i_fifo_data into the 32-bit shift register.
  - Set byte counter=3.
  - Go to SEND.
- SEND:
  - Wait while i_tx_active=1.
  - When i_tx_active=0: drive o_tx_byte_data with the current byte and pulse o_tx_byte_send_sig. Go to WAIT_DONE.
  - Current byte is shift[31:24] when MSB_FIRST=1, shift[7:0] when MSB_FIRST=0.
- WAIT_DONE:
  - o_tx_byte_data holds stable until i_tx_done_sig is seen.
  - On i_tx_done_sig with byte counter≠0: shift the register by 8 toward the send end, zero-fill, decrement the counter, go to SEND.
  - On i_tx_done_sig with byte counter=0: pulse o_word_sent_sig and go to IDLE.
- Latency: the first send strobe is FIFO_RD_LATENCY+2 cycles after rd_en, provided TX is idle.
- Throughput:
  - One byte per TX done, plus 1 cycle of turnaround per byte.
  - Back-to-back words: the next rd_en is issued no earlier than the cycle after o_word_sent_sig.
- Boundary conditions:
  - i_tx_done_sig arriving in any state other than WAIT_DONE (e.g. a stale done from a prior byte) is ignored and never advances the counter.
  - The FIFO going empty mid-word has no effect; the word already latched completes.
  - Reset mid-word: the remaining bytes are discarded and the word is not re-read. No o_word_sent_sig is generated for the partial word.
  - There is never more than one outstanding FIFO read, and rd_en is never asserted while i_fifo_empty=1.
  - The byte counter is 2 bits; counting down from 3 to 0 gives exactly 4 bytes with no wrap.

Test Plan:
- Single word: FIFO holds 32'hDEADBEEF, TX model with 10-cycle done latency, MSB_FIRST=1 → bytes DE, AD, BE, EF in order. Exactly 4 send strobes, 1 rd_en, 1 o_word_sent_sig. FIFO empty afterwards, o_busy=0.
- Round trip: words 32'h01234567, 32'h89ABCDEF → serialiser → TX model → deserialiser. The deserialiser outputs the identical two words; the second rd_en occurs only after the first o_word_sent_sig.
- Empty FIFO: i_fifo_empty=1 for 100 cycles → o_fifo_rd_en, o_tx_byte_send_sig and o_busy stay 0.
- TX backpressure: i_tx_active held 1 for 50 cycles while in SEND → no send strobe is issued. The strobe fires the cycle after i_tx_active falls, and o_tx_byte_data is stable throughout.
- Spurious done and reset: inject i_tx_done_sig while in IDLE, then in SEND → the byte counter is unchanged. Next, assert i_reset after the 2nd byte of 32'hCAFEF00D → all outputs 0 immediately with no o_word_sent_sig. The next FIFO word then starts from its first byte.
- FIFO_RD_LATENCY=3 and MSB_FIRST=0 with word 32'h11223344 → bytes 44, 33, 22, 11. The first send strobe comes 5 cycles after rd_en.
